// File: rtl/aibcr3pnr_rstseq.sv
// Multi-channel reset synchronizer and staggered release sequencer; ch k releases SYNC_STAGES+HOLD+k*STAGGER edges after reset.
// Assertion is asynchronous on every channel; no backpressure, sw_rst_req restarts the hold window on any sampled edge.
module aibcr3pnr_rstseq #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_mode_n,
    input  logic [NUM_CH-1:0] rst_n_bypass,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_sync,
    output logic              seq_done,
    output logic [1:0]        seq_state
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam bit ONE_SHOT = (NUM_CH == 1) || (STAGGER_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic                   int_rst;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rise;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_CH-1:0]      ch_q, ch_d;
    logic                   done_q, done_d;

    // In scan mode the tester owns the reset through bypass bit 0.
    assign int_rst = scan_mode_n ? rst : ~rst_n_bypass[0];

    always_ff @(posedge clk or posedge int_rst) begin
        if (int_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge int_rst) begin
        if (int_rst) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        done_d  = done_q;
        case (state_q)
            ST_RESET: begin
                if (sync_rise) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (ONE_SHOT) begin
                        ch_d    = '1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ch_d    = NUM_CH'(1);
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STAG_LAST) begin
                    cnt_d = '0;
                    // Thermometer shift keeps release strictly in channel order.
                    ch_d  = (ch_q << 1) | NUM_CH'(1);
                    if (&ch_d) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
            end
        endcase
        // A software request beats any release scheduled for the same edge.
        if (sw_rst_req && (state_q != ST_RESET)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            ch_d    = '0;
            done_d  = 1'b0;
        end
    end

    assign rst_n_sync = scan_mode_n ? ch_q : rst_n_bypass;
    assign seq_done   = done_q;
    assign seq_state  = state_q;

endmodule

// File: doc/aibcr3pnr_rstseq.md
Name: aibcr3pnr_rstseq

Overview:
Parametrised multi-channel reset synchronizer and release sequencer for AIB PnR partitions. Reset assertion is asynchronous on all channels. Deassertion is synchronized to clk through a configurable-depth synchronizer, held for a minimum stretch, then released channel by channel with a programmable stagger. The block adds a synchronous software re-reset request and keeps per-channel scan bypass. It drives the active-low reset trees of NUM_CH downstream sub-blocks sharing one clock.

Parameters:
NUM_CH, 4, number of output reset channels (1..16)
SYNC_STAGES, 3, synchronizer flop depth (2..5)
HOLD_CYCLES, 8, clk cycles between synchronized deassertion and release of channel 0 (1..255)
STAGGER_CYCLES, 4, clk cycles between consecutive channel releases (0..255; 0 = all channels released together)

Ports:
clk  input  1  destination clock; all sequencing on rising edge
rst  input  1  asynchronous, active-high reset
scan_mode_n  input  1  0 = scan mode (bypass), 1 = functional
rst_n_bypass  input  NUM_CH  per-channel reset used in scan mode; bit 0 also drives internal reset in scan
sw_rst_req  input  1  synchronous (clk-domain) re-reset request, level-sampled
rst_n_sync  output  NUM_CH  active-low synchronized channel resets
seq_done  output  1  high once every channel is released
seq_state  output  2  FSM state: 0 RESET, 1 HOLD, 2 RELEASE, 3 DONE

Behaviour:
- Internal async reset: rst when scan_mode_n=1; ~rst_n_bypass[0] when scan_mode_n=0.
- Internal async reset asserted -> immediately, with no clock: rst_n_sync=all 0, seq_done=0, seq_state=RESET, counters=0, synchronizer flops=0.
- Synchronizer: SYNC_STAGES flops reset to 0, shifting in 1. Output goes high on edge SYNC_STAGES after deassertion. Edge 1 is the first rising edge after deassertion.
- Reference edge E: the edge on which the synchronizer output first goes high (E = SYNC_STAGES), or the edge that samples sw_rst_req=1.
- Release timing: rst_n_sync[k] rises on edge E + HOLD_CYCLES + k*STAGGER_CYCLES. seq_done rises on the same edge as rst_n_sync[NUM_CH-1]. Defaults give ch0 @11, ch1 @15, ch2 @19, ch3 @23, seq_done @23.
- FSM:
  - RESET -> HOLD on edge E.
  - HOLD: cycle counter runs; -> RELEASE on the edge that releases ch0.
  - RELEASE: stagger counter runs; channel index increments on each release.
  - -> DONE on the edge that releases the last channel.
  - NUM_CH=1 or STAGGER_CYCLES=0: HOLD -> DONE directly, with all channels rising on the same edge.
- Released channels stay high until the next reset or sw_rst_req. A channel is never released out of order.
- sw_rst_req:
  - Sampled high in HOLD, RELEASE or DONE -> on that edge, rst_n_sync=all 0, seq_done=0, state=HOLD, counters cleared. That edge becomes the new E.
  - Held high: restarts every cycle, so outputs stay low.
  - Ignored in RESET.
  - Sampled on the same edge a channel would release: the request wins, and the channel stays low.
- rst asserted mid-sequence: async clear as above. The full sequence restarts from the synchronizer after deassertion.
- Counters: width clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1); they never wrap within a sequence.
- Scan (scan_mode_n=0): rst_n_sync = rst_n_bypass combinationally, per bit. The internal FSM follows the internal reset. seq_done and seq_state reflect the internal FSM.
- Outputs are glitch-free in functional mode: rst_n_sync and seq_done are flop outputs muxed only by scan_mode_n.

Test Plan:
1. Defaults, rst high 5 cycles then low at edge 0 -> rst_n_sync 4'b0000 through edge 10; bits rise at edges 11/15/19/23; seq_done=1 at edge 23; seq_state sequence 0,1,2,3.
2. rst reasserted at edge 17 (ch0, ch1 released) -> rst_n_sync=0 and seq_done=0 within the same cycle without a clock edge. After release at edge 0, the full sequence repeats with ch0 at edge 11.
3. In DONE, sw_rst_req=1 for one cycle at edge E=40 -> all channels low after edge 40; ch0..3 rise at 48/52/56/60. With req held for 3 cycles (edges 40..42) -> ch0 rises at 50.
4. sw_rst_req pulse at edge 14, one edge before the ch1 release at 15 -> ch1 stays low at 15; ch0 drops; the new sequence runs with ch0 at 22.
5. Overrides:
   - STAGGER_CYCLES=0, HOLD_CYCLES=1, SYNC_STAGES=2 -> all channels and seq_done rise at edge 3; seq_state goes 0,1,3.
   - NUM_CH=1 -> ch0 and seq_done rise together at edge SYNC_STAGES+HOLD_CYCLES.
6. scan_mode_n=0, rst_n_bypass toggled 4'b1010 <-> 4'b0101 -> rst_n_sync tracks combinationally. rst_n_bypass[0]=0 holds the FSM in RESET regardless of rst.
